// File: rtl/data_mem_arb_pkg.sv
// rtl/data_mem_arb_pkg.sv - shared types and constants for the data memory arbiter
package data_mem_arb_pkg;

  localparam int WAIT_CNT_W = 4;

  typedef enum logic {
    ARB_SHARED = 1'b0,
    ARB_LOCK_B = 1'b1
  } arb_state_e;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_e;

endpackage

// File: rtl/arb_wait_counter.sv
// rtl/arb_wait_counter.sv - saturating count of consecutive cycles port B was denied
module arb_wait_counter
  import data_mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic Clock,
  input  logic Reset,
  input  logic clr_i,
  input  logic inc_i,
  output logic at_limit_o
);

  localparam logic [WAIT_CNT_W-1:0] LIMIT = WAIT_CNT_W'(MAX_WAIT);

  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit_o = (cnt_q == LIMIT);

endmodule

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - shares the single-ported data memory between CPU (A) and debug (B)
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 30,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              A_Req,
  input  logic              A_Wr,
  input  logic [ADDR_W-1:0] A_Addr,
  input  logic [DATA_W-1:0] A_Data_W,
  output logic              A_Gnt,
  output logic              A_Valid_R,
  input  logic              B_Req,
  input  logic              B_Wr,
  input  logic [ADDR_W-1:0] B_Addr,
  input  logic [DATA_W-1:0] B_Data_W,
  output logic              B_Gnt,
  output logic              B_Valid_R,
  input  logic              B_Lock,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic              Mem_En_W,
  output logic              Mem_En_R,
  output logic [DATA_W-1:0] Mem_Data_W,
  input  logic [DATA_W-1:0] Mem_Data_R,
  output logic [DATA_W-1:0] Data_R,
  output logic              Locked
);

  arb_state_e state_q;
  owner_e     owner_q;
  logic       valid_q;
  logic       b_at_limit;
  logic       shared;
  logic       a_gnt, b_gnt, granted, wr_sel;

  assign shared = (state_q == ARB_SHARED);

  // B's bounded wait overrides A's priority; in LOCK_B only B may win.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (!Reset) begin
      if (shared) begin
        if (B_Req && b_at_limit) begin
          b_gnt = 1'b1;
        end else if (A_Req) begin
          a_gnt = 1'b1;
        end else if (B_Req) begin
          b_gnt = 1'b1;
        end
      end else begin
        b_gnt = B_Req;
      end
    end
  end

  arb_wait_counter #(
    .MAX_WAIT(MAX_WAIT)
  ) u_wait_cnt (
    .Clock     (Clock),
    .Reset     (Reset),
    .clr_i     (shared && (b_gnt || !B_Req)),
    .inc_i     (shared && B_Req && !b_gnt),
    .at_limit_o(b_at_limit)
  );

  assign granted    = a_gnt || b_gnt;
  assign wr_sel     = b_gnt ? B_Wr : A_Wr;
  assign Mem_Addr   = b_gnt ? B_Addr : A_Addr;
  assign Mem_Data_W = b_gnt ? B_Data_W : A_Data_W;
  assign Mem_En_W   = granted && wr_sel;
  assign Mem_En_R   = granted && !wr_sel;
  assign A_Gnt      = a_gnt;
  assign B_Gnt      = b_gnt;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ARB_SHARED;
      valid_q <= 1'b0;
      owner_q <= OWN_A;
    end else begin
      case (state_q)
        ARB_SHARED: if (b_gnt && B_Lock) state_q <= ARB_LOCK_B;
        ARB_LOCK_B: if (!B_Lock) state_q <= ARB_SHARED;
        default:    state_q <= ARB_SHARED;
      endcase
      valid_q <= granted && !wr_sel;
      owner_q <= b_gnt ? OWN_B : OWN_A;
    end
  end

  // Gated by Reset so a read granted just before reset never reports valid.
  assign A_Valid_R = valid_q && (owner_q == OWN_A) && !Reset;
  assign B_Valid_R = valid_q && (owner_q == OWN_B) && !Reset;
  assign Locked    = (state_q == ARB_LOCK_B) && !Reset;
  assign Data_R    = Mem_Data_R;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - vector-table bench for data_mem_arbiter with a simple memory model
module tb_data_mem_arbiter;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        A_Req, A_Wr, B_Req, B_Wr, B_Lock;
  logic [29:0] A_Addr, B_Addr, Mem_Addr;
  logic [31:0] A_Data_W, B_Data_W, Mem_Data_W, Mem_Data_R, Data_R;
  logic        A_Gnt, A_Valid_R, B_Gnt, B_Valid_R, Mem_En_W, Mem_En_R, Locked;

  int checks = 0;
  int passed = 0;

  data_mem_arbiter #(.ADDR_W(30), .DATA_W(32), .MAX_WAIT(4)) dut (
    .Clock(Clock), .Reset(Reset),
    .A_Req(A_Req), .A_Wr(A_Wr), .A_Addr(A_Addr), .A_Data_W(A_Data_W),
    .A_Gnt(A_Gnt), .A_Valid_R(A_Valid_R),
    .B_Req(B_Req), .B_Wr(B_Wr), .B_Addr(B_Addr), .B_Data_W(B_Data_W),
    .B_Gnt(B_Gnt), .B_Valid_R(B_Valid_R), .B_Lock(B_Lock),
    .Mem_Addr(Mem_Addr), .Mem_En_W(Mem_En_W), .Mem_En_R(Mem_En_R),
    .Mem_Data_W(Mem_Data_W), .Mem_Data_R(Mem_Data_R), .Data_R(Data_R),
    .Locked(Locked)
  );

  always #5 Clock = ~Clock;

  // Memory model: unwritten words read as 0xA000_0000 | addr.
  logic [31:0] mem [64];
  logic [63:0] written = '0;
  always @(posedge Clock) begin
    if (Mem_En_W) begin
      mem[Mem_Addr[5:0]]     <= Mem_Data_W;
      written[Mem_Addr[5:0]] <= 1'b1;
    end
    if (Mem_En_R) begin
      Mem_Data_R <= written[Mem_Addr[5:0]] ? mem[Mem_Addr[5:0]]
                                           : (32'hA000_0000 | {26'd0, Mem_Addr[5:0]});
    end
  end

  // fi = {Reset, A_Req, A_Wr, B_Req, B_Wr, B_Lock}
  // fe = {A_Gnt, B_Gnt, Mem_En_W, Mem_En_R, A_Valid_R, B_Valid_R, Locked}
  typedef struct {
    string       name;
    logic [5:0]  fi;
    logic [29:0] aa;
    logic [31:0] ad;
    logic [29:0] ba;
    logic [31:0] bd;
    logic [6:0]  fe;
    logic [29:0] ea;
    logic [31:0] ed;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(string n, logic [5:0] fi, logic [29:0] aa, logic [31:0] ad,
                             logic [29:0] ba, logic [31:0] bd, logic [6:0] fe,
                             logic [29:0] ea, logic [31:0] ed);
    vec_t r;
    r.name = n; r.fi = fi; r.aa = aa; r.ad = ad; r.ba = ba; r.bd = bd;
    r.fe = fe; r.ea = ea; r.ed = ed;
    return r;
  endfunction

  task automatic check(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
  endtask

  task automatic apply(vec_t x);
    {Reset, A_Req, A_Wr, B_Req, B_Wr, B_Lock} = x.fi;
    A_Addr = x.aa; A_Data_W = x.ad; B_Addr = x.ba; B_Data_W = x.bd;
    @(negedge Clock);
    check({x.name, " flags"}, {25'd0, A_Gnt, B_Gnt, Mem_En_W, Mem_En_R, A_Valid_R, B_Valid_R, Locked},
          {25'd0, x.fe});
    if (x.fe[4] || x.fe[3]) check({x.name, " addr"}, {2'b0, Mem_Addr}, {2'b0, x.ea});
    if (x.fe[2] || x.fe[1]) check({x.name, " data"}, Data_R, x.ed);
    @(posedge Clock);
    #1;
  endtask

  initial begin
    //                      fi         aa     ad            ba     bd            fe          ea     ed
    vecs.push_back(v("rst0",   6'b100000, 30'h0,  32'h0,        30'h0,  32'h0,        7'b0000000, 30'h0,  32'h0));
    vecs.push_back(v("rst1",   6'b110000, 30'h10, 32'h0,        30'h0,  32'h0,        7'b0000000, 30'h0,  32'h0));
    vecs.push_back(v("ab_rd",  6'b010100, 30'h10, 32'h0,        30'h20, 32'h0,        7'b1001000, 30'h10, 32'h0));
    vecs.push_back(v("b_rd",   6'b000100, 30'h0,  32'h0,        30'h20, 32'h0,        7'b0101100, 30'h20, 32'hA000_0010));
    vecs.push_back(v("b_vld",  6'b000000, 30'h0,  32'h0,        30'h0,  32'h0,        7'b0000010, 30'h0,  32'hA000_0020));
    vecs.push_back(v("st1",    6'b010100, 30'h1,  32'h0,        30'h30, 32'h0,        7'b1001000, 30'h1,  32'h0));
    vecs.push_back(v("st2",    6'b010100, 30'h2,  32'h0,        30'h30, 32'h0,        7'b1001100, 30'h2,  32'hA000_0001));
    vecs.push_back(v("st3",    6'b010100, 30'h3,  32'h0,        30'h30, 32'h0,        7'b1001100, 30'h3,  32'hA000_0002));
    vecs.push_back(v("st4",    6'b010100, 30'h4,  32'h0,        30'h30, 32'h0,        7'b1001100, 30'h4,  32'hA000_0003));
    vecs.push_back(v("forced", 6'b010100, 30'h5,  32'h0,        30'h30, 32'h0,        7'b0101100, 30'h30, 32'hA000_0004));
    vecs.push_back(v("st5",    6'b010100, 30'h5,  32'h0,        30'h31, 32'h0,        7'b1001010, 30'h5,  32'hA000_0030));
    vecs.push_back(v("st6",    6'b010100, 30'h6,  32'h0,        30'h31, 32'h0,        7'b1001100, 30'h6,  32'hA000_0005));
    vecs.push_back(v("st7",    6'b010100, 30'h7,  32'h0,        30'h31, 32'h0,        7'b1001100, 30'h7,  32'hA000_0006));
    vecs.push_back(v("st8",    6'b010100, 30'h8,  32'h0,        30'h31, 32'h0,        7'b1001100, 30'h8,  32'hA000_0007));
    vecs.push_back(v("forced2",6'b010100, 30'h9,  32'h0,        30'h31, 32'h0,        7'b0101100, 30'h31, 32'hA000_0008));
    vecs.push_back(v("idle1",  6'b000000, 30'h0,  32'h0,        30'h0,  32'h0,        7'b0000010, 30'h0,  32'hA000_0031));
    vecs.push_back(v("lk_wr",  6'b000111, 30'h0,  32'h0,        30'h3,  32'hDEADBEEF, 7'b0110000, 30'h3,  32'h0));
    vecs.push_back(v("lk_rd1", 6'b010101, 30'h9,  32'h0,        30'h3,  32'h0,        7'b0101001, 30'h3,  32'h0));
    vecs.push_back(v("lk_rd2", 6'b010101, 30'h9,  32'h0,        30'h4,  32'h0,        7'b0101011, 30'h4,  32'hDEADBEEF));
    vecs.push_back(v("lk_rd3", 6'b010101, 30'h9,  32'h0,        30'h5,  32'h0,        7'b0101011, 30'h5,  32'hA000_0004));
    vecs.push_back(v("unlock", 6'b010000, 30'h9,  32'h0,        30'h0,  32'h0,        7'b0000011, 30'h0,  32'hA000_0005));
    vecs.push_back(v("a_back", 6'b010000, 30'h9,  32'h0,        30'h0,  32'h0,        7'b1001000, 30'h9,  32'h0));
    vecs.push_back(v("lk2",    6'b000101, 30'h0,  32'h0,        30'h6,  32'h0,        7'b0101100, 30'h6,  32'hA000_0009));
    vecs.push_back(v("lk2_drop",6'b010100,30'hA,  32'h0,        30'h7,  32'h0,        7'b0101011, 30'h7,  32'hA000_0006));
    vecs.push_back(v("lk2_sh", 6'b010000, 30'hA,  32'h0,        30'h0,  32'h0,        7'b1001010, 30'hA,  32'hA000_0007));
    vecs.push_back(v("idle2",  6'b000000, 30'h0,  32'h0,        30'h0,  32'h0,        7'b0000100, 30'h0,  32'hA000_000A));
    vecs.push_back(v("a_wr",   6'b011000, 30'h7,  32'h12345678, 30'h0,  32'h0,        7'b1010000, 30'h7,  32'h0));
    vecs.push_back(v("a_rd",   6'b010000, 30'h7,  32'h0,        30'h0,  32'h0,        7'b1001000, 30'h7,  32'h0));
    vecs.push_back(v("a_rdv",  6'b000000, 30'h0,  32'h0,        30'h0,  32'h0,        7'b0000100, 30'h0,  32'h12345678));
    vecs.push_back(v("pre_rst",6'b000101, 30'h0,  32'h0,        30'h20, 32'h0,        7'b0101000, 30'h20, 32'h0));
    vecs.push_back(v("rst_a",  6'b110101, 30'h1,  32'h0,        30'h2,  32'h0,        7'b0000000, 30'h0,  32'h0));
    vecs.push_back(v("rst_b",  6'b110101, 30'h1,  32'h0,        30'h2,  32'h0,        7'b0000000, 30'h0,  32'h0));
    vecs.push_back(v("post",   6'b010100, 30'h1,  32'h0,        30'h2,  32'h0,        7'b1001000, 30'h1,  32'h0));
    vecs.push_back(v("post_v", 6'b000000, 30'h0,  32'h0,        30'h0,  32'h0,        7'b0000100, 30'h0,  32'hA000_0001));

    {Reset, A_Req, A_Wr, B_Req, B_Wr, B_Lock} = 6'b100000;
    A_Addr = '0; A_Data_W = '0; B_Addr = '0; B_Data_W = '0;
    @(posedge Clock);
    #1;

    foreach (vecs[i]) apply(vecs[i]);

    for (int c = 0; c < 10; c++) begin
      {Reset, A_Req, A_Wr, B_Req, B_Wr, B_Lock} = 6'b000000;
      @(negedge Clock);
      check($sformatf("idle10_%0d", c),
            {25'd0, A_Gnt, B_Gnt, Mem_En_W, Mem_En_R, A_Valid_R, B_Valid_R, Locked}, 32'd0);
      @(posedge Clock);
      #1;
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port arbiter that shares the single-ported data memory between the CPU memory stage (port A) and the debug/program-loader port (port B). Grants one access per cycle, drives the memory enables, address and write data from the winner, and returns a per-port read-valid one cycle later. Port A has priority, but a bounded-wait counter prevents starvation of port B. Port B may lock the memory for bursts. Sits between the CPU/debug masters and the data memory wrapper.

## Interface
- ADDR_W, 30: word-address width, passed through to memory.
- DATA_W, 32: data width.
- MAX_WAIT, 4: consecutive denied cycles after which port B is forced to win; legal range 1..15.

- Clock  in  1  single clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high.
- A_Req, A_Wr  in  1 each  port A request; write (1) or read (0).
- A_Addr  in  ADDR_W  port A word address.
- A_Data_W  in  DATA_W  port A write data.
- A_Gnt  out  1  port A access taken this cycle.
- A_Valid_R  out  1  Mem_Data_R holds port A read data.
- B_Req, B_Wr, B_Addr, B_Data_W, B_Gnt, B_Valid_R: same as port A, for port B.
- B_Lock  in  1  port B requests exclusive ownership.
- Mem_Addr  out  ADDR_W  memory address.
- Mem_En_W, Mem_En_R  out  1 each  memory write/read enables.
- Mem_Data_W  out  DATA_W  memory write data.
- Mem_Data_R  in  DATA_W  memory read data, one cycle after Mem_En_R.
- Data_R  out  DATA_W  Mem_Data_R passed through to both ports.
- Locked  out  1  FSM is in LOCK_B.

## Operation
- FSM states: SHARED (reset state) and LOCK_B.
- SHARED, win rule:
  - B wins if B_Req and Wait_Cnt == MAX_WAIT.
  - Otherwise A wins if A_Req.
  - Otherwise B wins if B_Req.
- LOCK_B: only B can win, when B_Req; A_Gnt held 0.
- Transitions:
  - SHARED -> LOCK_B at the edge where B_Gnt=1 and B_Lock=1.
  - LOCK_B -> SHARED at any edge with B_Lock=0, regardless of B_Req.
- Wait_Cnt, 4 bits:
  - Cleared on reset, when B_Gnt=1, or when B_Req=0.
  - Otherwise increments each cycle B_Req=1 and B_Gnt=0.
  - Saturates at MAX_WAIT.
  - Not updated in LOCK_B (B is never denied there).
- Winner mux:
  - Mem_Addr and Mem_Data_W come from the winner.
  - Mem_En_W = winner Wr; Mem_En_R = !winner Wr.
  - No winner: both enables 0; Mem_Addr and Mem_Data_W are don't-care (drive port A values).
- Read return:
  - Registered owner bit plus valid bit.
  - A_Valid_R / B_Valid_R asserted exactly one cycle after that port's read grant.
  - Writes never produce a valid.
- Handshake:
  - A requester holds Req, Wr, Addr and Data_W stable until it samples Gnt=1 at an edge.
  - Dropping Req before grant is legal; nothing is issued.
- Reset:
  - While Reset=1: Gnt, enables, Valid_R and Locked are 0; FSM goes to SHARED; Wait_Cnt = 0.
  - A read granted in the cycle before Reset rises produces no Valid_R.

## Timing
- A_Gnt, B_Gnt, Mem_En_W/R, Mem_Addr and Mem_Data_W are combinational from the request inputs, FSM state and Wait_Cnt. Zero-latency grant, so the CPU memory stage can access memory in a single cycle.
- Read latency: grant cycle N -> Valid_R and Data_R valid in cycle N+1. Back-to-back reads by the same or alternating ports sustain one access per cycle.
- Locked, Valid_R, Wait_Cnt and FSM state are registered; all reset values are 0 / SHARED.
- Simultaneous events:
  - A_Req with B forced: B wins; A's Wait is not counted and A retries.
  - B_Lock dropped in the same cycle as a B grant in LOCK_B: access completes, SHARED next cycle.

## Structure
- Package data_mem_arb_pkg:
  - Arbiter state enum (ARB_SHARED, ARB_LOCK_B).
  - Owner encoding (OWN_A=0, OWN_B=1).
  - Wait_Cnt width constant.
- Sub-module arb_wait_counter: saturating wait counter with clear, increment and at-limit output, parameterized by MAX_WAIT.
- Everything else lives in data_mem_arbiter.

## Test plan
- A read 0x10 and B read 0x20 in the same cycle, B_Lock=0 -> A_Gnt=1, Mem_Addr=0x10, Mem_En_R=1; next cycle A_Valid_R=1, B still waiting.
- A_Req held high continuously, B_Req high, MAX_WAIT=4 -> B_Gnt=1 on the 5th cycle of B's request, A_Gnt=0 that cycle, Wait_Cnt back to 0.
- B write 0xDEADBEEF to 0x3 with B_Lock=1, then 3 B reads while A_Req=1 -> Locked=1 from the next cycle, A_Gnt=0 throughout. B_Lock=0 -> SHARED next cycle and A is granted.
- A write to 0x7, then A read to 0x7 on the next cycle -> Mem_En_W then Mem_En_R. A_Valid_R only in the cycle after the read; Data_R = written value.
- Reset asserted the cycle after a B read grant and held 2 cycles -> B_Valid_R=0, Locked=0, all enables 0 during reset; first request after reset is granted normally.
- No requests for 10 cycles -> Mem_En_W=Mem_En_R=0, both Gnt and both Valid_R low.
